// File: rtl/shifto_miso_rx.sv
// shifto_miso_rx: SPI receive deserialiser for the SD-card link (CPOL=0, CPHA=0).
// Samples the asynchronous sclk, MISO and cs_n through synchronisers on the system
// clock, shifts MISO in MSB first on each synchronised sclk rise, and hands each
// completed N-bit word to the consumer through a valid/ack hold register.
//
// Ports:
//   clk      system clock
//   resetn   asynchronous active-low reset
//   sclk     SPI serial clock (asynchronous, synchronised here)
//   cs_n     card select, active low; high aborts any partial word
//   MISO     serial data from the card
//   dataRe   last complete word, held until overwritten
//   valid    dataRe holds an unacknowledged word
//   ack      consumer has taken dataRe
//   overrun  sticky: a word completed while valid was still set
//   busy     a frame is partially received
module shifto_miso_rx #(
    parameter int unsigned N    = 8,
    parameter int unsigned SYNC = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         MISO,
    output logic [N-1:0] dataRe,
    output logic         valid,
    input  logic         ack,
    output logic         overrun,
    output logic         busy
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LastBit = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StShift, StLoad} state_t;

    logic [SYNC-1:0] sclk_sync, miso_sync, csn_sync;
    logic            sclk_q;
    state_t          state_q, state_d;
    logic [CW-1:0]   bitcnt_q, bitcnt_d;
    logic [N-1:0]    sh_q, sh_d;
    logic [N-1:0]    data_q, data_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;

    logic         sclk_s, miso_s, cs_s, rise;
    logic [N-1:0] shifted;

    assign sclk_s  = sclk_sync[SYNC-1];
    assign miso_s  = miso_sync[SYNC-1];
    assign cs_s    = csn_sync[SYNC-1];
    assign rise    = sclk_s & ~sclk_q;
    assign shifted = {sh_q[N-2:0], miso_s};

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        sh_d      = sh_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (ack && valid_q) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle, StShift: begin
                if (cs_s) begin
                    bitcnt_d = '0;
                    sh_d     = '1;
                    state_d  = StIdle;
                end else if (rise) begin
                    sh_d = shifted;
                    if (bitcnt_q == LastBit) begin
                        bitcnt_d = '0;
                        state_d  = StLoad;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        state_d  = StShift;
                    end
                end
            end
            StLoad: begin
                // A load takes priority over a concurrent ack, so the ack does not
                // count as having consumed the previous word: overrun is flagged.
                data_d  = sh_q;
                valid_d = 1'b1;
                if (valid_q) begin
                    overrun_d = 1'b1;
                end
                bitcnt_d = '0;
                state_d  = StIdle;
                if (cs_s) begin
                    sh_d = '1;
                end else if (rise) begin
                    // First bit of the next word lands in the load cycle itself.
                    sh_d     = shifted;
                    bitcnt_d = CW'(1);
                    state_d  = StShift;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_sync <= '0;
            miso_sync <= '1;
            csn_sync  <= '1;
            sclk_q    <= 1'b0;
            state_q   <= StIdle;
            bitcnt_q  <= '0;
            sh_q      <= '1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC-2:0], sclk};
            miso_sync <= {miso_sync[SYNC-2:0], MISO};
            csn_sync  <= {csn_sync[SYNC-2:0], cs_n};
            sclk_q    <= sclk_s;
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign dataRe  = data_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign busy    = (bitcnt_q != '0);

endmodule

// File: tb/tb_shifto_miso_rx.sv
// tb_shifto_miso_rx: directed bench for shifto_miso_rx with a word-level reference
// model compared against the outputs on every clock, plus literal spot checks.
module tb_shifto_miso_rx;

    localparam int unsigned N    = 8;
    localparam int unsigned SYNC = 2;

    logic         clk;
    logic         resetn;
    logic         sclk;
    logic         cs_n;
    logic         miso;
    logic         ack;
    logic [N-1:0] data_re;
    logic         valid;
    logic         overrun;
    logic         busy;

    shifto_miso_rx #(.N(N), .SYNC(SYNC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sclk   (sclk),
        .cs_n   (cs_n),
        .MISO   (miso),
        .dataRe (data_re),
        .valid  (valid),
        .ack    (ack),
        .overrun(overrun),
        .busy   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pin samples seen at each clock edge, delayed by the
    // synchroniser depth, assembled into words by plain arithmetic.
    logic [2:0]   hist[$];   // {sclk, miso, cs_n} per edge, oldest first
    int           m_bits;
    int           m_word;
    int           m_done;
    bit           m_load;
    logic [N-1:0] m_data;
    bit           m_valid;
    bit           m_ovr;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= int'(SYNC); i++) hist.push_back(3'b011);
        m_bits  = 0;
        m_word  = 0;
        m_done  = 0;
        m_load  = 1'b0;
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] cur;
        logic [2:0] prev;
        bit         rise;
        bit         nv;
        bit         nl;
        cur  = hist[hist.size() - SYNC];
        prev = hist[hist.size() - SYNC - 1];
        rise = cur[2] && !prev[2];
        nv   = m_valid && !ack;
        nl   = 1'b0;
        if (m_load) begin
            m_data = N'(m_done);
            if (m_valid) m_ovr = 1'b1;
            nv = 1'b1;
        end
        if (cur[0]) begin
            m_bits = 0;
            m_word = 0;
        end else if (rise) begin
            m_word = m_word * 2 + int'(cur[1]);
            m_bits++;
            if (m_bits == int'(N)) begin
                m_done = m_word;
                m_bits = 0;
                m_word = 0;
                nl     = 1'b1;
            end
        end
        m_valid = nv;
        m_load  = nl;
        hist.push_back({sclk, miso, cs_n});
        void'(hist.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else model_step();
        end
    end

    int vrise = 0;
    bit valid_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            chk("dataRe", 32'(data_re), 32'(m_data));
            chk("valid", 32'(valid), 32'(m_valid));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("busy", 32'(busy), 32'(m_bits != 0));
            if (valid && !valid_prev) vrise++;
            valid_prev = valid;
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: got no finish, expected finish within 1ms");
        $fatal(1, "timeout");
    end

    bit ack_at_load = 1'b0;
    int ack_hits = 0;

    task automatic tick();
        @(negedge clk);
        #1;
        ack = ack_at_load && m_load;
        if (ack) ack_hits++;
    endtask

    task automatic idle(input int n);
        sclk = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
    endtask

    // Sends the top nb bits of w, MSB first, at clk = 8 * sclk.
    task automatic send_bits(input logic [7:0] w, input int nb, input bit measure);
        int lat;
        lat = 0;
        for (int i = 0; i < nb; i++) begin
            sclk = 1'b0;
            miso = w[7-i];
            repeat (4) tick();
            sclk = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                tick();
                if (measure && i == nb - 1 && lat == 0 && valid) lat = k;
            end
        end
        if (measure) chk("latency", 32'(lat), 32'(SYNC + 2));
    endtask

    initial begin
        resetn = 1'b0;
        sclk   = 1'b0;
        cs_n   = 1'b1;
        miso   = 1'b1;
        ack    = 1'b0;

        // Reset held with sclk toggling
        for (int i = 0; i < 12; i++) begin
            sclk = ~sclk;
            tick();
            chk("rst_dataRe", 32'(data_re), 32'h0);
            chk("rst_valid", 32'(valid), 32'h0);
            chk("rst_overrun", 32'(overrun), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
        end
        resetn = 1'b1;
        cs_n   = 1'b0;
        idle(4);

        // Single word with latency measurement and ack
        send_bits(8'hA5, 8, 1'b1);
        chk("single_dataRe", 32'(data_re), 32'hA5);
        chk("single_model", 32'(m_data), 32'hA5);
        chk("single_valid", 32'(valid), 32'h1);
        pulse_ack();
        chk("single_ack_valid", 32'(valid), 32'h0);
        idle(4);

        // Back-to-back words without ack
        send_bits(8'h3C, 8, 1'b0);
        send_bits(8'hFF, 8, 1'b0);
        idle(8);
        chk("stream_dataRe", 32'(data_re), 32'hFF);
        chk("stream_valid", 32'(valid), 32'h1);
        chk("stream_overrun", 32'(overrun), 32'h1);
        chk("stream_model_ovr", 32'(m_ovr), 32'h1);
        pulse_ack();
        chk("stream_ack_valid", 32'(valid), 32'h0);
        chk("stream_ack_overrun", 32'(overrun), 32'h1);

        // Load and ack in the same cycle
        do_reset();
        idle(4);
        send_bits(8'h11, 8, 1'b0);
        idle(4);
        chk("simul_first_valid", 32'(valid), 32'h1);
        chk("simul_first_ovr", 32'(overrun), 32'h0);
        ack_hits    = 0;
        ack_at_load = 1'b1;
        send_bits(8'h22, 8, 1'b0);
        ack_at_load = 1'b0;
        idle(4);
        chk("simul_ack_hits", 32'(ack_hits), 32'd1);
        chk("simul_valid", 32'(valid), 32'h1);
        chk("simul_overrun", 32'(overrun), 32'h1);
        chk("simul_dataRe", 32'(data_re), 32'h22);
        pulse_ack();
        chk("simul_ack_valid", 32'(valid), 32'h0);
        idle(4);

        // Abort after 5 bits, then a full word
        vrise = 0;
        send_bits(8'h81, 5, 1'b0);
        chk("abort_busy_mid", 32'(busy), 32'h1);
        cs_n = 1'b1;
        for (int p = 0; p < 2; p++) begin
            sclk = 1'b0;
            repeat (4) tick();
            sclk = 1'b1;
            repeat (4) tick();
        end
        chk("abort_busy_cleared", 32'(busy), 32'h0);
        cs_n = 1'b0;
        idle(4);
        send_bits(8'h42, 8, 1'b0);
        idle(6);
        chk("abort_dataRe", 32'(data_re), 32'h42);
        chk("abort_model", 32'(m_data), 32'h42);
        chk("abort_valid", 32'(valid), 32'h1);
        chk("abort_vrise", 32'(vrise), 32'd1);
        pulse_ack();
        idle(4);

        // Reset mid-frame
        vrise = 0;
        send_bits(8'hC3, 4, 1'b0);
        chk("midrst_busy", 32'(busy), 32'h1);
        resetn = 1'b0;
        sclk   = 1'b0;
        repeat (2) tick();
        chk("midrst_dataRe", 32'(data_re), 32'h0);
        chk("midrst_valid", 32'(valid), 32'h0);
        chk("midrst_overrun", 32'(overrun), 32'h0);
        chk("midrst_busy0", 32'(busy), 32'h0);
        sclk = 1'b1;
        repeat (2) tick();
        resetn = 1'b1;
        idle(4);
        send_bits(8'h5A, 8, 1'b0);
        idle(6);
        chk("midrst_final_dataRe", 32'(data_re), 32'h5A);
        chk("midrst_final_valid", 32'(valid), 32'h1);
        chk("midrst_final_ovr", 32'(overrun), 32'h0);
        chk("midrst_vrise", 32'(vrise), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
